// File: rtl/bfxp_seq.sv
// Bit-field extract/place sequencer: walks up to NFIELDS field descriptors through
// an external one-cycle extract/place stage and ORs each result into an accumulator.
//
// state | meaning
// IDLE  | waiting for a request (req_ready high)
// RUN   | issuing descriptor idx to the extract stage, one per cycle
// DRAIN | folding the result of the last issued descriptor
// DONE  | presenting rsp_* until rsp_ready
module bfxp_seq #(
    parameter int NFIELDS = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_rs1,
    input  logic [31:0]            req_rs2,
    input  logic [15*NFIELDS-1:0]  req_desc,
    input  logic [2:0]             req_count,
    output logic [31:0]            bfx_rs1,
    output logic [31:0]            bfx_rs2,
    output logic [4:0]             bfx_start,
    output logic [4:0]             bfx_len,
    output logic [4:0]             bfx_dest,
    input  logic [31:0]            bfx_rd,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [31:0]            rs1_q;
    logic [15*NFIELDS-1:0]  desc_q;
    logic [2:0]             cnt_q;
    logic [2:0]             idx;
    logic [31:0]            acc;
    logic                   err;
    logic                   pend;
    logic                   rsp_valid_q;

    logic [2:0]             cnt_clamped;
    logic [14:0]            cur_desc;
    logic [4:0]             cur_start;
    logic [4:0]             cur_len;
    logic [4:0]             cur_dest;
    logic [5:0]             cur_end;
    logic                   cur_ok;

    assign cnt_clamped = (req_count > 3'(NFIELDS)) ? 3'(NFIELDS) : req_count;

    always_comb begin
        cur_desc = '0;
        for (int i = 0; i < NFIELDS; i++) begin
            if (idx == 3'(i)) begin
                cur_desc = desc_q[15*i +: 15];
            end
        end
    end

    assign cur_start = cur_desc[4:0];
    assign cur_len   = cur_desc[9:5];
    assign cur_dest  = cur_desc[14:10];
    // The field end is formed one bit wider so dest+len cannot wrap past 32.
    assign cur_end   = {1'b0, cur_dest} + {1'b0, cur_len};
    assign cur_ok    = (cur_len != 5'd0) && (cur_end <= 6'd32);

    // Handshake outputs are forced low while reset is held, before the reset edge lands.
    assign req_ready = (state == IDLE) && resetn;
    assign rsp_valid = rsp_valid_q && resetn;

    assign bfx_rs1 = rs1_q;
    assign bfx_rs2 = 32'd0;

    always_comb begin
        bfx_start = 5'd0;
        bfx_len   = 5'd0;
        bfx_dest  = 5'd0;
        if (state == RUN && cur_ok) begin
            bfx_start = cur_start;
            bfx_len   = cur_len;
            bfx_dest  = cur_dest;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            rs1_q       <= '0;
            desc_q      <= '0;
            cnt_q       <= '0;
            idx         <= '0;
            acc         <= '0;
            err         <= 1'b0;
            pend        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rs1_q  <= req_rs1;
                        desc_q <= req_desc;
                        cnt_q  <= cnt_clamped;
                        acc    <= req_rs2;
                        idx    <= 3'd0;
                        err    <= 1'b0;
                        pend   <= 1'b0;
                        state  <= (cnt_clamped == 3'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pend) begin
                        acc <= acc | bfx_rd;
                    end
                    pend <= cur_ok;
                    // Zero-length slots are silently skipped; only overflowing fields flag err.
                    if (cur_len != 5'd0 && !cur_ok) begin
                        err <= 1'b1;
                    end
                    idx <= idx + 3'd1;
                    if (idx == cnt_q - 3'd1) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pend) begin
                        acc <= acc | bfx_rd;
                    end
                    pend  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_data    <= acc;
                        rsp_err     <= err;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bfxp_seq.md
BFXP_SEQ -- requirements
Module: bfxp_seq

Interface
REQ-001 SHALL have parameter NFIELDS, default 4, giving the number of field descriptors per request (1..7).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, request offered.
REQ-005 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready at a clock edge.
REQ-006 SHALL have port req_rs1, input, 32, source word the fields are extracted from.
REQ-007 SHALL have port req_rs2, input, 32, initial accumulator value.
REQ-008 SHALL have port req_desc, input, 15*NFIELDS; descriptor i occupies bits [15i+14:15i] as start[4:0], len[9:5], dest[14:10].
REQ-009 SHALL have port req_count, input, 3, number of descriptors used; values above NFIELDS are treated as NFIELDS.
REQ-010 SHALL have ports bfx_rs1/bfx_rs2 (output, 32 each) and bfx_start/bfx_len/bfx_dest (output, 5 each), driving the downstream bit-field extract/place stage.
REQ-011 SHALL have port bfx_rd, input, 32, that stage's registered result, valid one cycle after its inputs.
REQ-012 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 32) and rsp_err (output, 1).

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE; req_ready = 1 only in IDLE.
REQ-014 On acceptance, SHALL latch rs1, desc and the clamped count; SHALL set acc = req_rs2, idx = 0, err = 0 and pend = 0.
REQ-015 On acceptance with count 0, SHALL go to DONE; otherwise SHALL go to RUN.
REQ-016 In RUN, SHALL issue descriptor idx each cycle:
- bfx_rs1 = latched rs1; bfx_rs2 = 0.
- bfx_start/len/dest = descriptor fields.
REQ-017 A descriptor SHALL be valid iff len != 0 and dest+len <= 32, computed in 6-bit unsigned arithmetic.
REQ-018 For an invalid descriptor, SHALL drive bfx_start/len/dest = 0 for that slot.
REQ-019 For an invalid descriptor with len != 0, SHALL set err sticky-high; len == 0 is a silent skip.
REQ-020 SHALL register pend = validity of the slot just issued.
REQ-021 Every RUN or DRAIN cycle with pend = 1, SHALL update acc |= bfx_rd.
REQ-022 SHALL increment idx per RUN cycle; after issuing idx = count-1, SHALL go to DRAIN.
REQ-023 DRAIN SHALL last exactly one cycle, then go to DONE.
REQ-024 Outside RUN, SHALL drive bfx_start, bfx_len, bfx_dest and bfx_rs2 to 0.
REQ-025 In DONE, SHALL hold rsp_valid = 1 with rsp_data = acc and rsp_err = err, stable until rsp_ready.
REQ-026 SHALL return to IDLE on the edge where rsp_valid && rsp_ready.
REQ-027 Latency: accept at edge 0, count = k >= 1: rsp_valid SHALL rise after edge k+2; for k = 0, after edge 1.
REQ-028 A new request SHALL NOT be accepted in the cycle a response completes; req_ready rises the following cycle.
REQ-029 Inputs req_* SHALL be ignored outside IDLE.
REQ-030 bfx_rd SHALL be ignored when pend = 0.

Reset
REQ-031 At any edge with resetn = 0, SHALL enter IDLE from any state, aborting any in-flight request without a response.
REQ-032 On reset, SHALL clear acc, idx, pend, err, rsp_data and rsp_err to 0.
REQ-033 rsp_valid and req_ready SHALL be 0 while resetn = 0; req_ready SHALL be 1 in the first cycle after release.

Verification
REQ-034 Single field: rs1=0x000000F0, rs2=0x100, count=1, desc0 {start=4, len=4, dest=0} -> rsp_data=0x10F, rsp_err=0, rsp_valid 3 cycles after accept.
REQ-035 Two fields: rs1=0xAB0000CD, rs2=0, desc0 {0,8,0}, desc1 {24,8,8} -> rsp_data=0x0000ABCD, rsp_err=0, valid 4 cycles after accept.
REQ-036 Overflow and skip: desc0 {0,4,30}, desc1 {0,0,0}, rs2=0x5 -> rsp_data=0x5, rsp_err=1, no bfx_rd folded.
REQ-037 Backpressure: rsp_ready low 3 cycles in DONE -> rsp_data/rsp_err stable, req_ready=0 throughout; handshake on 4th cycle, req_ready=1 next cycle.
REQ-038 Reset mid-RUN: resetn=0 during second RUN cycle of a count=3 request -> IDLE, rsp_valid never asserted, acc=0; next request processes normally.
REQ-039 count=0 with rs2=0x12345678 -> rsp_data=0x12345678 one cycle after accept; count=7 with NFIELDS=4 -> exactly 4 issue cycles.
